// File: rtl/mini_src_cu_pkg.sv
// Shared definitions for the Mini-SRC control unit: opcodes, IR field positions,
// state encoding, instruction classes and the memory-latency range.
package mini_src_cu_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_SHR  = 5'h04;
    localparam logic [4:0] OP_SHRA = 5'h05;
    localparam logic [4:0] OP_SHL  = 5'h06;
    localparam logic [4:0] OP_ROR  = 5'h07;
    localparam logic [4:0] OP_ROL  = 5'h08;
    localparam logic [4:0] OP_ADDI = 5'h09;
    localparam logic [4:0] OP_ANDI = 5'h0A;
    localparam logic [4:0] OP_ORI  = 5'h0B;
    localparam logic [4:0] OP_MUL  = 5'h0C;
    localparam logic [4:0] OP_DIV  = 5'h0D;
    localparam logic [4:0] OP_NEG  = 5'h0E;
    localparam logic [4:0] OP_NOT  = 5'h0F;
    localparam logic [4:0] OP_NOP  = 5'h18;
    localparam logic [4:0] OP_HALT = 5'h1B;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam int NUM_REGS  = 16;
    localparam int REG_SEL_W = 4;

    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } cu_state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_t;

    function automatic instr_class_t classify(input logic [4:0] op);
        instr_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: cls = CLS_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:        cls = CLS_IMM;
            OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                  cls = CLS_UNARY;
            OP_NOP:                          cls = CLS_NOP;
            OP_HALT:                         cls = CLS_HALT;
            default:                         cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-16 register select decoder: picks Ra/Rb/Rc via Gra/Grb/Grc and drives
// one-hot R0-R15 load enables (Rin) or bus-source selects (Rout).
module reg_select_decoder
    import mini_src_cu_pkg::*;
(
    input  logic [REG_SEL_W-1:0] Ra,
    input  logic [REG_SEL_W-1:0] Rb,
    input  logic [REG_SEL_W-1:0] Rc,
    input  logic                 Gra,
    input  logic                 Grb,
    input  logic                 Grc,
    input  logic                 Rin,
    input  logic                 Rout,
    output logic [NUM_REGS-1:0]  R0_15_in,
    output logic [NUM_REGS-1:0]  R0_15_out
);

    logic [REG_SEL_W-1:0] sel;
    logic [NUM_REGS-1:0]  onehot;
    logic                 any_sel;

    always_comb begin
        sel = '0;
        if (Gra) begin
            sel = Ra;
        end else if (Grb) begin
            sel = Rb;
        end else if (Grc) begin
            sel = Rc;
        end
        any_sel   = Gra | Grb | Grc;
        onehot    = {{(NUM_REGS-1){1'b0}}, 1'b1} << sel;
        R0_15_in  = (Rin  && any_sel) ? onehot : '0;
        R0_15_out = (Rout && any_sel) ? onehot : '0;
    end

endmodule

// File: rtl/mini_src_control_unit.sv
// Mini-SRC control sequencer: T-state fetch/execute FSM driving datapath strobes.
// Define CU_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with a sticky flag.
module mini_src_control_unit
    import mini_src_cu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)
(
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        LOout,
    output logic        HIout,
    output logic        MDRout,
    output logic        Cout,
    output logic [15:0] R0_15_out,
    output logic [15:0] R0_15_in,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  opcode,
    output logic        halted,
    output logic        illegal
);

    localparam int LAT = (MEM_LATENCY < MEM_LATENCY_MIN) ? MEM_LATENCY_MIN :
                         (MEM_LATENCY > MEM_LATENCY_MAX) ? MEM_LATENCY_MAX : MEM_LATENCY;
    localparam logic [3:0] LAST_WAIT = 4'(LAT - 1);

    cu_state_t    state;
    cu_state_t    state_next;
    cu_state_t    end_state;
    instr_class_t cls;
    logic [3:0]   wait_cnt;
    logic         first_wait;
    logic         last_wait;
    logic [4:0]   op;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [3:0]   rc;
    logic         gra;
    logic         grb;
    logic         grc;
    logic         r_in;
    logic         r_out;
    logic         unused_ir_bits;

    assign op             = IR[OP_MSB:OP_LSB];
    assign ra             = IR[RA_MSB:RA_LSB];
    assign rb             = IR[RB_MSB:RB_LSB];
    assign rc             = IR[RC_MSB:RC_LSB];
    assign cls            = classify(op);
    assign first_wait     = (wait_cnt == 4'd0);
    assign last_wait      = (wait_cnt == LAST_WAIT);
    assign unused_ir_bits = ^IR[14:0];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts cycles spent in T1 while the memory read completes.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wait_cnt <= 4'd0;
        end else if (state == ST_T1 && !last_wait) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            illegal_q <= 1'b0;
        end else if (state == ST_T2 && cls == CLS_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_next = state;
        end_state  = run ? ST_T0 : ST_IDLE;
        PCout      = 1'b0;
        Zhighout   = 1'b0;
        Zlowout    = 1'b0;
        LOout      = 1'b0;
        HIout      = 1'b0;
        MDRout     = 1'b0;
        Cout       = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Zhighin    = 1'b0;
        Zlowin     = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        opcode     = 5'd0;
        halted     = 1'b0;
        gra        = 1'b0;
        grb        = 1'b0;
        grc        = 1'b0;
        r_in       = 1'b0;
        r_out      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_T0;
            end
            ST_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zhighin    = 1'b1;
                Zlowin     = 1'b1;
                state_next = ST_T1;
            end
            // PC update happens once; Read stays up until the last wait cycle.
            ST_T1: begin
                Read = 1'b1;
                if (first_wait) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
                if (last_wait) begin
                    MDRin      = 1'b1;
                    state_next = ST_T2;
                end
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                case (cls)
                    CLS_NOP:     state_next = end_state;
                    CLS_HALT:    state_next = ST_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
                    CLS_ILLEGAL: state_next = ST_HALT;
`else
                    CLS_ILLEGAL: state_next = end_state;
`endif
                    default:     state_next = ST_T3;
                endcase
            end
            ST_T3: begin
                r_out      = 1'b1;
                state_next = ST_T4;
                if (cls == CLS_MULDIV) begin
                    gra = 1'b1;
                    Yin = 1'b1;
                end else if (cls == CLS_UNARY) begin
                    grb     = 1'b1;
                    opcode  = op;
                    Zhighin = 1'b1;
                    Zlowin  = 1'b1;
                end else begin
                    grb = 1'b1;
                    Yin = 1'b1;
                end
            end
            ST_T4: begin
                if (cls == CLS_UNARY) begin
                    Zlowout    = 1'b1;
                    gra        = 1'b1;
                    r_in       = 1'b1;
                    state_next = end_state;
                end else begin
                    opcode     = op;
                    Zhighin    = 1'b1;
                    Zlowin     = 1'b1;
                    state_next = ST_T5;
                    if (cls == CLS_IMM) begin
                        Cout = 1'b1;
                    end else begin
                        r_out = 1'b1;
                        grb   = (cls == CLS_MULDIV);
                        grc   = (cls != CLS_MULDIV);
                    end
                end
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (cls == CLS_MULDIV) begin
                    LOin       = 1'b1;
                    state_next = ST_T6;
                end else begin
                    gra        = 1'b1;
                    r_in       = 1'b1;
                    state_next = end_state;
                end
            end
            ST_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                state_next = end_state;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    reg_select_decoder u_reg_select_decoder (
        .Ra        (ra),
        .Rb        (rb),
        .Rc        (rc),
        .Gra       (gra),
        .Grb       (grb),
        .Grc       (grc),
        .Rin       (r_in),
        .Rout      (r_out),
        .R0_15_in  (R0_15_in),
        .R0_15_out (R0_15_out)
    );

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Scoreboard bench for mini_src_control_unit: two instances (MEM_LATENCY 1 and 3)
// driven with random instructions and compared cycle by cycle to a reference model.
module tb_mini_src_control_unit;

    typedef struct packed {
        logic        pc_out;
        logic        zh_out;
        logic        zl_out;
        logic        lo_out;
        logic        hi_out;
        logic        mdr_out;
        logic        c_out;
        logic [15:0] r_out;
        logic [15:0] r_in;
        logic        mar_in;
        logic        pc_in;
        logic        mdr_in;
        logic        ir_in;
        logic        y_in;
        logic        hi_in;
        logic        lo_in;
        logic        zh_in;
        logic        zl_in;
        logic        inc_pc;
        logic        read;
        logic [4:0]  opc;
        logic        halted;
        logic        illegal;
    } ctl_t;

    localparam int CW = $bits(ctl_t);

`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef enum {M_IDLE, M_BUSY, M_HALT} mode_t;

    logic        clock;
    logic        clear;
    logic        run;
    logic [31:0] ir_v [2];
    wire  [CW-1:0] act_w [2];

    int          vectors;
    int          miscompares;
    int          lat_of [2] = '{1, 3};
    mode_t       mode [2];
    bit          end_halt [2];
    bit          end_ill [2];
    bit          ill [2];
    logic [31:0] cur_ir [2];
    ctl_t        pend [2][$];
    ctl_t        exp_q [2][$];
    logic [31:0] plan [2][$];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : lane
        logic        PCout, Zhighout, Zlowout, LOout, HIout, MDRout, Cout;
        logic [15:0] R0_15_out, R0_15_in;
        logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, IncPC, Read;
        logic [4:0]  opcode;
        logic        halted, illegal;

        mini_src_control_unit #(.MEM_LATENCY(g == 0 ? 1 : 3)) dut (
            .clock     (clock),
            .clear     (clear),
            .run       (run),
            .IR        (ir_v[g]),
            .PCout     (PCout),
            .Zhighout  (Zhighout),
            .Zlowout   (Zlowout),
            .LOout     (LOout),
            .HIout     (HIout),
            .MDRout    (MDRout),
            .Cout      (Cout),
            .R0_15_out (R0_15_out),
            .R0_15_in  (R0_15_in),
            .MARin     (MARin),
            .PCin      (PCin),
            .MDRin     (MDRin),
            .IRin      (IRin),
            .Yin       (Yin),
            .HIin      (HIin),
            .LOin      (LOin),
            .Zhighin   (Zhighin),
            .Zlowin    (Zlowin),
            .IncPC     (IncPC),
            .Read      (Read),
            .opcode    (opcode),
            .halted    (halted),
            .illegal   (illegal)
        );

        assign act_w[g] = {PCout, Zhighout, Zlowout, LOout, HIout, MDRout, Cout,
                           R0_15_out, R0_15_in, MARin, PCin, MDRin, IRin, Yin,
                           HIin, LOin, Zhighin, Zlowin, IncPC, Read, opcode,
                           halted, illegal};

        // Monitor: every expected cycle pushed by the driver is popped here.
        always @(negedge clock) begin
            if (exp_q[g].size() > 0) begin
                checkOutput(g, exp_q[g].pop_front(), ctl_t'(act_w[g]));
            end
        end
    end

    task automatic checkOutput(input int l, input ctl_t exp_v, input ctl_t act_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL lane%0d ctl_vector t=%0t: got %h, expected %h",
                     l, $time, act_v, exp_v);
        end
    endtask

    // Expected control vectors for one whole instruction, from fetch to its last cycle.
    task automatic buildSeq(input int l, input logic [31:0] ir);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        ctl_t       t;
        op = ir[31:27];
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        end_halt[l] = 1'b0;
        end_ill[l]  = 1'b0;
        pend[l].delete();

        t = '0; t.pc_out = 1; t.mar_in = 1; t.inc_pc = 1; t.zh_in = 1; t.zl_in = 1;
        pend[l].push_back(t);
        for (int w = 0; w < lat_of[l]; w++) begin
            t = '0; t.read = 1;
            if (w == 0) begin t.zl_out = 1; t.pc_in = 1; end
            if (w == lat_of[l] - 1) t.mdr_in = 1;
            pend[l].push_back(t);
        end
        t = '0; t.mdr_out = 1; t.ir_in = 1;
        pend[l].push_back(t);

        if (op <= 5'h0B) begin
            t = '0; t.r_out = 16'd1 << rb; t.y_in = 1;
            pend[l].push_back(t);
            t = '0; t.opc = op; t.zh_in = 1; t.zl_in = 1;
            if (op >= 5'h09) t.c_out = 1;
            else             t.r_out = 16'd1 << rc;
            pend[l].push_back(t);
            t = '0; t.zl_out = 1; t.r_in = 16'd1 << ra;
            pend[l].push_back(t);
        end else if (op == 5'h0C || op == 5'h0D) begin
            t = '0; t.r_out = 16'd1 << ra; t.y_in = 1;
            pend[l].push_back(t);
            t = '0; t.r_out = 16'd1 << rb; t.opc = op; t.zh_in = 1; t.zl_in = 1;
            pend[l].push_back(t);
            t = '0; t.zl_out = 1; t.lo_in = 1;
            pend[l].push_back(t);
            t = '0; t.zh_out = 1; t.hi_in = 1;
            pend[l].push_back(t);
        end else if (op == 5'h0E || op == 5'h0F) begin
            t = '0; t.r_out = 16'd1 << rb; t.opc = op; t.zh_in = 1; t.zl_in = 1;
            pend[l].push_back(t);
            t = '0; t.zl_out = 1; t.r_in = 16'd1 << ra;
            pend[l].push_back(t);
        end else if (op == 5'h1B) begin
            end_halt[l] = 1'b1;
        end else if (op != 5'h18 && TRAP) begin
            end_halt[l] = 1'b1;
            end_ill[l]  = 1'b1;
        end
    endtask

    task automatic startInstr(input int l);
        logic [31:0] r;
        if (plan[l].size() > 0) begin
            cur_ir[l] = plan[l].pop_front();
        end else begin
            r = $urandom;
            r[31:27] = ($urandom_range(0, 16) == 16) ? 5'h18 : 5'($urandom_range(0, 15));
            cur_ir[l] = r;
        end
        buildSeq(l, cur_ir[l]);
        mode[l] = M_BUSY;
    endtask

    // One clock period: drive inputs, queue what each lane must show, advance the model.
    task automatic applyStimulus(input bit clr_n, input bit run_v);
        ctl_t e;
        clear = clr_n;
        run   = run_v;
        for (int l = 0; l < 2; l++) begin
            ir_v[l] = cur_ir[l];
            e = '0;
            if (clr_n) begin
                if (mode[l] == M_HALT) begin
                    e.halted  = 1'b1;
                    e.illegal = ill[l];
                end else if (mode[l] == M_BUSY) begin
                    e = pend[l].pop_front();
                end
            end
            exp_q[l].push_back(e);

            if (!clr_n) begin
                mode[l] = M_IDLE;
                pend[l].delete();
                ill[l] = 1'b0;
            end else if (mode[l] == M_IDLE) begin
                if (run_v) startInstr(l);
            end else if (mode[l] == M_BUSY && pend[l].size() == 0) begin
                if (end_halt[l]) begin
                    mode[l] = M_HALT;
                    ill[l]  = ill[l] | end_ill[l];
                end else if (run_v) begin
                    startInstr(l);
                end else begin
                    mode[l] = M_IDLE;
                end
            end
        end
    endtask

    function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    initial begin
        clock       = 1'b0;
        clear       = 1'b0;
        run         = 1'b0;
        vectors     = 0;
        miscompares = 0;
        for (int l = 0; l < 2; l++) begin
            ir_v[l]   = '0;
            cur_ir[l] = '0;
            mode[l]   = M_IDLE;
            ill[l]    = 1'b0;
            plan[l].push_back(32'h0190_8000);
            plan[l].push_back(32'h0190_8000);
            plan[l].push_back(mkIr(5'h0C, 4'd4, 4'd5, 19'd0));
            plan[l].push_back(mkIr(5'h09, 4'd2, 4'd2, 19'h7FFFB));
            plan[l].push_back(mkIr(5'h0E, 4'd7, 4'd9, 19'd0));
            plan[l].push_back(mkIr(5'h0F, 4'd15, 4'd0, 19'd0));
            plan[l].push_back(mkIr(5'h18, 4'd0, 4'd0, 19'd0));
            plan[l].push_back(mkIr(5'h1F, 4'd1, 4'd2, 19'd0));
        end

        for (int k = 0; k < 570; k++) begin
            @(posedge clock);
            #1;
            if (k < 3) begin
                applyStimulus(1'b0, 1'b0);
            end else if (k == 8) begin
                applyStimulus(1'b0, 1'b1);
            end else if (k < 70) begin
                applyStimulus(1'b1, 1'b1);
            end else if (k < 500) begin
                applyStimulus($urandom_range(0, 79) != 0, $urandom_range(0, 9) != 0);
            end else begin
                if (k == 500) begin
                    plan[0].push_back(32'hD800_0000);
                    plan[1].push_back(32'hD800_0000);
                end
                applyStimulus(1'b1, (k < 530) ? 1'b1 : 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clock);
        #1;
        for (int l = 0; l < 2; l++) begin
            vectors++;
            if (exp_q[l].size() != 0) begin
                miscompares++;
                $display("[TB] FAIL lane%0d drain: got %0d unchecked entries, expected 0",
                         l, exp_q[l].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
